// File: rtl/cpu_types_pkg.sv
// Purpose: shared CPU types for the memory arbiter and its users.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IREQ   = 2'd1,
        DREQ   = 2'd2,
        HALTED = 2'd3
    } arb_state_t;

    // Load value handed back when the RAM never answers.
    localparam word_t ERR_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_arb_timer.sv
// Purpose: clearable up-counter that flags when a grant has run TIMEOUT_CYCLES cycles.
// Latency: tc is combinational from the registered count.
// Backpressure: none; the count holds at terminal count until cleared.
//
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-high reset
//   clr  in   synchronous clear (takes priority over en)
//   en   in   count enable
//   tc   out  count has reached TIMEOUT_CYCLES-1
module mem_arb_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && !tc) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc = (count_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: shares one single-ported RAM between instruction fetch and data load/store.
// Latency: request seen in IDLE -> strobe next cycle; wait drops in the ram_ready cycle (min 2).
// Backpressure: requesters see wait=1 until their completion cycle; RAM stalls via ram_ready.
//
// Ports:
//   CLK, RST                          clock and asynchronous active-high reset
//   iren, iaddr / iwait, iload        instruction read port
//   dren, dwen, daddr, dstore /
//   dwait, dload                      data read/write port (dwen wins over dren)
//   halt / halted                     drain and park request / parked indicator
//   err                               sticky timeout flag
//   ram_ren, ram_wen, ram_addr,
//   ram_store / ram_load, ram_ready   RAM side, one access at a time
module mem_arbiter
    import cpu_types_pkg::word_t,
           cpu_types_pkg::arb_state_t,
           cpu_types_pkg::IDLE,
           cpu_types_pkg::IREQ,
           cpu_types_pkg::DREQ,
           cpu_types_pkg::HALTED;
#(
    parameter int    MAX_DSTREAK    = 2,
    parameter int    TIMEOUT_CYCLES = 64,
    parameter word_t ERR_WORD       = cpu_types_pkg::ERR_WORD
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  iren,
    input  word_t iaddr,
    output logic  iwait,
    output word_t iload,
    input  logic  dren,
    input  logic  dwen,
    input  word_t daddr,
    input  word_t dstore,
    output logic  dwait,
    output word_t dload,
    input  logic  halt,
    output logic  halted,
    output logic  err,
    output logic  ram_ren,
    output logic  ram_wen,
    output word_t ram_addr,
    output word_t ram_store,
    input  word_t ram_load,
    input  logic  ram_ready
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    arb_state_t      state_q, state_d;
    logic [SW-1:0]   dstreak_q, dstreak_d;
    word_t           addr_q, addr_d;
    word_t           data_q, data_d;
    logic            wr_q, wr_d;
    logic            err_q, err_d;

    logic            busy;
    logic            fin;
    logic            tout;
    logic            tc;
    word_t           result;

    mem_arb_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk (CLK),
        .rst (RST),
        .clr (state_q == IDLE),
        .en  (busy && !ram_ready),
        .tc  (tc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            dstreak_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
        end
    end

    // A real ram_ready in the terminal cycle counts as a normal completion.
    assign busy   = (state_q == IREQ) || (state_q == DREQ);
    assign fin    = busy && (ram_ready || tc);
    assign tout   = fin && !ram_ready;
    assign result = tout ? ERR_WORD : ram_load;

    always_comb begin
        state_d   = state_q;
        dstreak_d = dstreak_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_d      = wr_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                // Data wins unless it has used up its streak while fetch waits.
                if ((dren || dwen) && ((dstreak_q < STREAK_MAX) || !iren)) begin
                    state_d = DREQ;
                    addr_d  = daddr;
                    data_d  = dstore;
                    wr_d    = dwen;
                    if (dstreak_q != STREAK_MAX) begin
                        dstreak_d = dstreak_q + 1'b1;
                    end
                end else if (iren) begin
                    state_d   = IREQ;
                    addr_d    = iaddr;
                    data_d    = '0;
                    wr_d      = 1'b0;
                    dstreak_d = '0;
                end else if (halt) begin
                    state_d = HALTED;
                end
            end
            IREQ, DREQ: begin
                if (fin) begin
                    state_d = IDLE;
                    if (tout) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign ram_ren   = busy && !wr_q;
    assign ram_wen   = busy && wr_q;
    assign ram_addr  = busy ? addr_q : '0;
    assign ram_store = (busy && wr_q) ? data_q : '0;

    assign iwait  = !(fin && (state_q == IREQ));
    assign dwait  = !(fin && (state_q == DREQ));
    assign iload  = iwait ? '0 : result;
    assign dload  = (!dwait && !wr_q) ? result : '0;
    assign halted = (state_q == HALTED);
    assign err    = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int          MAX_DSTREAK = 2;
    localparam int          TO          = 8;
    localparam logic [31:0] ERRW        = 32'hBAD1BAD1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iren = 1'b0;
    logic [31:0] iaddr = '0;
    logic        iwait;
    logic [31:0] iload;
    logic        dren = 1'b0;
    logic        dwen = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        dwait;
    logic [31:0] dload;
    logic        halt = 1'b0;
    logic        halted;
    logic        err;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic [31:0] ram_load = '0;
    logic        ram_ready = 1'b0;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .MAX_DSTREAK    (MAX_DSTREAK),
        .TIMEOUT_CYCLES (TO),
        .ERR_WORD       (ERRW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .iren      (iren),
        .iaddr     (iaddr),
        .iwait     (iwait),
        .iload     (iload),
        .dren      (dren),
        .dwen      (dwen),
        .daddr     (daddr),
        .dstore    (dstore),
        .dwait     (dwait),
        .dload     (dload),
        .halt      (halt),
        .halted    (halted),
        .err       (err),
        .ram_ren   (ram_ren),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_store (ram_store),
        .ram_load  (ram_load),
        .ram_ready (ram_ready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Transaction-level reference: the access in flight (if any), how long
    // it has been outstanding, how many data grants in a row since the last
    // fetch grant, and whether the arbiter has parked.
    bit          m_busy, m_is_data, m_wr, m_halted, m_err;
    logic [31:0] m_addr, m_data;
    int          m_elapsed, m_streak;
    int          n_igrant, n_dgrant, n_tout;

    task automatic model_reset();
        m_busy = 0; m_is_data = 0; m_wr = 0; m_halted = 0; m_err = 0;
        m_addr = '0; m_data = '0; m_elapsed = 0; m_streak = 0;
    endtask

    task automatic check_outputs();
        bit          done, timed_out;
        logic [31:0] word;
        done      = m_busy && (ram_ready || (m_elapsed == TO - 1));
        timed_out = done && !ram_ready;
        word      = timed_out ? ERRW : ram_load;
        check_eq("ram_ren",   32'(ram_ren),   32'(m_busy && !m_wr));
        check_eq("ram_wen",   32'(ram_wen),   32'(m_busy && m_wr));
        check_eq("ram_addr",  ram_addr,       m_busy ? m_addr : 32'h0);
        check_eq("ram_store", ram_store,      (m_busy && m_wr) ? m_data : 32'h0);
        check_eq("iwait",     32'(iwait),     32'(!(done && !m_is_data)));
        check_eq("dwait",     32'(dwait),     32'(!(done && m_is_data)));
        check_eq("iload",     iload,          (done && !m_is_data) ? word : 32'h0);
        check_eq("dload",     dload,          (done && m_is_data && !m_wr) ? word : 32'h0);
        check_eq("halted",    32'(halted),    32'(m_halted));
        check_eq("err",       32'(err),       32'(m_err));
    endtask

    task automatic model_step();
        bit done;
        done = m_busy && (ram_ready || (m_elapsed == TO - 1));
        if (m_busy) begin
            if (done) begin
                if (!ram_ready) begin
                    m_err = 1;
                    n_tout++;
                end
                m_busy    = 0;
                m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
        end else if (!m_halted) begin
            if ((dren || dwen) && (m_streak < MAX_DSTREAK || !iren)) begin
                m_busy = 1; m_is_data = 1; m_wr = dwen;
                m_addr = daddr; m_data = dstore; m_elapsed = 0;
                m_streak++;
                n_dgrant++;
            end else if (iren) begin
                m_busy = 1; m_is_data = 0; m_wr = 0;
                m_addr = iaddr; m_elapsed = 0;
                m_streak = 0;
                n_igrant++;
            end else if (halt) begin
                m_halted = 1;
            end
        end
    endtask

    task automatic drive_random(input int ready_pct, input int halt_pct);
        int r;
        iren      = ($urandom_range(0, 99) < 70);
        r         = $urandom_range(0, 3);
        dren      = (r == 1) || (r == 3);
        dwen      = (r == 2) || (r == 3);
        iaddr     = $urandom;
        daddr     = $urandom;
        dstore    = $urandom;
        ram_load  = $urandom;
        ram_ready = ($urandom_range(0, 99) < ready_pct);
        halt      = ($urandom_range(0, 99) < halt_pct);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        iren = 0; dren = 0; dwen = 0; halt = 0; ram_ready = 0;
        iaddr = '0; daddr = '0; dstore = '0; ram_load = '0;
        repeat (2) @(negedge CLK);
        #1;
        model_reset();
        check_outputs();
        RST = 1'b0;
    endtask

    int ready_pct_tab [4] = '{70, 30, 5, 100};

    initial begin
        n_igrant = 0; n_dgrant = 0; n_tout = 0;
        model_reset();
        for (int p = 0; p < 4; p++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                @(negedge CLK);
                drive_random(ready_pct_tab[p], (c > 220) ? 3 : 0);
                if (m_busy && ($urandom_range(0, 99) == 0)) begin
                    // Asynchronous reset between edges must drop the access at once.
                    RST = 1'b1;
                    #1;
                    check_eq("mr_ram_ren", 32'(ram_ren), 32'h0);
                    check_eq("mr_ram_wen", 32'(ram_wen), 32'h0);
                    check_eq("mr_iwait",   32'(iwait),   32'h1);
                    check_eq("mr_dwait",   32'(dwait),   32'h1);
                    check_eq("mr_err",     32'(err),     32'h0);
                    check_eq("mr_halted",  32'(halted),  32'h0);
                    model_reset();
                    @(posedge CLK);
                    #2;
                    RST = 1'b0;
                    continue;
                end
                #1;
                check_outputs();
                model_step();
            end
        end
        check_eq("saw_ifetch_grants", 32'(n_igrant > 20), 32'h1);
        check_eq("saw_data_grants",   32'(n_dgrant > 20), 32'h1);
        check_eq("saw_timeouts",      32'(n_tout > 0),    32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
